// File: rtl/cola_buyer.sv
// Customer-side coin/cola initiator: pays PRICE coins spaced by GAP idle cycles,
// then waits up to TIMEOUT cycles for the vending machine's cola pulse.
module cola_buyer #(
  parameter int unsigned PRICE   = 3,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_buy,
  input  logic       pi_cola,
  output logic       po_money,
  output logic       po_busy,
  output logic [3:0] po_paid,
  output logic       po_done,
  output logic       po_timeout
);

  localparam logic [3:0] PRICE_N  = 4'(PRICE);
  localparam logic [7:0] GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAY  = 2'd1,
    S_GAP  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       money_nx, busy_nx, done_nx, timeout_nx;
  logic [3:0] paid_nx;

  logic last_coin, gap_end, wait_end;

  assign last_coin = (po_paid == PRICE_N);
  assign gap_end   = (cnt == GAP_LAST);
  assign wait_end  = (cnt == TO_LAST);

  // cnt is shared: gap cycles in S_GAP, WAIT-state timer in S_WAIT
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      po_money   <= 1'b0;
      po_busy    <= 1'b0;
      po_paid    <= '0;
      po_done    <= 1'b0;
      po_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      po_money   <= money_nx;
      po_busy    <= busy_nx;
      po_paid    <= paid_nx;
      po_done    <= done_nx;
      po_timeout <= timeout_nx;
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE: state_nx = pi_buy ? S_PAY : S_IDLE;
      S_PAY: begin
        if (last_coin)     state_nx = S_WAIT;
        else if (GAP == 0) state_nx = S_PAY;
        else               state_nx = S_GAP;
      end
      S_GAP:  state_nx = gap_end ? S_PAY : S_GAP;
      S_WAIT: state_nx = (pi_cola || wait_end) ? S_IDLE : S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered outputs are the values the next state presents; cola beats timeout.
  always_comb begin
    money_nx   = 1'b0;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    paid_nx    = po_paid;
    cnt_nx     = cnt;
    case (state)
      S_IDLE: begin
        if (pi_buy) begin
          money_nx = 1'b1;
          busy_nx  = 1'b1;
          paid_nx  = 4'd1;
          cnt_nx   = '0;
        end
      end
      S_PAY: begin
        busy_nx = 1'b1;
        cnt_nx  = '0;
        if (!last_coin && GAP == 0) begin
          money_nx = 1'b1;
          paid_nx  = po_paid + 4'd1;
        end
      end
      S_GAP: begin
        busy_nx = 1'b1;
        if (gap_end) begin
          money_nx = 1'b1;
          paid_nx  = po_paid + 4'd1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (pi_cola) begin
          done_nx = 1'b1;
        end else if (wait_end) begin
          timeout_nx = 1'b1;
        end else begin
          busy_nx = 1'b1;
          cnt_nx  = cnt + 8'd1;
        end
      end
      default: begin
        paid_nx = '0;
        cnt_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cola_buyer.sv
// Scoreboard bench for cola_buyer: a transaction-level model predicts coin and
// result events per request; monitors pop and compare whenever the DUT emits one.
module tb_cola_buyer;

  typedef struct {
    int cyc;
    int kind;   // 0 coin, 1 done, 2 timeout
    int paid;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       buy0, cola0, buy1, cola1;
  logic       money0, busy0, done0, tmo0;
  logic       money1, busy1, done1, tmo1;
  logic [3:0] paid0, paid1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  int   bz_from[2];
  int   bz_to[2];

  cola_buyer #(.PRICE(3), .GAP(2), .TIMEOUT(8)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_buy(buy0), .pi_cola(cola0),
    .po_money(money0), .po_busy(busy0), .po_paid(paid0),
    .po_done(done0), .po_timeout(tmo0)
  );

  cola_buyer #(.PRICE(1), .GAP(0), .TIMEOUT(8)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_buy(buy1), .pi_cola(cola1),
    .po_money(money1), .po_busy(busy1), .po_paid(paid1),
    .po_done(done1), .po_timeout(tmo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic qpush(input int id, input ev_t e);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  function automatic int qsz(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qpop(input int id);
    return (id == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic int qfront_cyc(input int id);
    return (id == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  task automatic on_cycle(input int id, input int c, input int money, input int done,
                          input int tmo, input int busy, input int paid);
    ev_t e;
    while (qsz(id) > 0 && qfront_cyc(id) < c) begin
      e = qpop(id);
      checks++;
      errors++;
      $display("FAIL dut%0d missed event: kind %0d expected at cycle %0d, still absent at cycle %0d",
               id, e.kind, e.cyc, c);
    end
    check($sformatf("dut%0d busy", id), busy, (c >= bz_from[id] && c <= bz_to[id]) ? 1 : 0);
    if (money + done + tmo > 0) begin
      check($sformatf("dut%0d one-hot money/done/timeout", id), money + done + tmo, 1);
      if (qsz(id) == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected event: money=%0d done=%0d timeout=%0d at cycle %0d, expected none",
                 id, money, done, tmo, c);
      end else begin
        e = qpop(id);
        check($sformatf("dut%0d event cycle", id), c, e.cyc);
        check($sformatf("dut%0d event kind", id), money ? 0 : (done ? 1 : 2), e.kind);
        check($sformatf("dut%0d paid", id), paid, e.paid);
      end
    end
  endtask

  always @(negedge clk) begin
    on_cycle(0, cyc, int'(money0), int'(done0), int'(tmo0), int'(busy0), int'(paid0));
    on_cycle(1, cyc, int'(money1), int'(done1), int'(tmo1), int'(busy1), int'(paid1));
  end

  task automatic drive(input int id, input int ntx, input bit hold);
    int  price, gap, to, c, t0, r, w, cola_c, next_req, n, mode;
    bit  b, k;
    ev_t e;
    price  = (id == 0) ? 3 : 1;
    gap    = (id == 0) ? 2 : 0;
    to     = 8;
    t0     = -1;
    r      = -1;
    cola_c = -1;
    n      = 0;
    next_req = cyc + 1 + int'($urandom_range(0, 2));
    while (n < ntx || cyc <= r) begin
      @(negedge clk);
      c = cyc;
      b = 1'b0;
      k = (c == cola_c);
      if (n < ntx && c == next_req) begin
        b  = 1'b1;
        t0 = c;
        for (int i = 0; i < price; i++) begin
          e.cyc  = t0 + 1 + i * (gap + 1);
          e.kind = 0;
          e.paid = i + 1;
          qpush(id, e);
        end
        w    = t0 + 1 + (price - 1) * (gap + 1) + 1;
        mode = int'($urandom_range(0, 3));
        case (mode)
          0: cola_c = -1;
          1: cola_c = w + int'($urandom_range(0, to - 1));
          2: cola_c = w + to - 1;
          default: cola_c = (w - 1 >= t0 + 2) ? int'($urandom_range(t0 + 2, w - 1)) : w + to;
        endcase
        if (cola_c >= w && cola_c <= w + to - 1) begin
          r      = cola_c + 1;
          e.kind = 1;
        end else begin
          r      = w + to;
          e.kind = 2;
        end
        e.cyc  = r;
        e.paid = price;
        qpush(id, e);
        bz_from[id] = t0 + 1;
        bz_to[id]   = r - 1;
        n++;
        next_req = hold ? r : r + int'($urandom_range(0, 3));
      end else if (hold ? (n > 0 && c < r) : (c > t0 && c < r && $urandom_range(0, 3) == 0)) begin
        b = 1'b1;
      end
      if (id == 0) begin buy0 = b; cola0 = k; end
      else         begin buy1 = b; cola1 = k; end
    end
    if (id == 0) begin buy0 = 1'b0; cola0 = 1'b0; end
    else         begin buy1 = 1'b0; cola1 = 1'b0; end
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, " dut0 money"}, int'(money0), 0);
    check({tag, " dut0 busy"}, int'(busy0), 0);
    check({tag, " dut0 paid"}, int'(paid0), 0);
    check({tag, " dut0 done"}, int'(done0), 0);
    check({tag, " dut0 timeout"}, int'(tmo0), 0);
    check({tag, " dut1 money"}, int'(money1), 0);
    check({tag, " dut1 busy"}, int'(busy1), 0);
    check({tag, " dut1 paid"}, int'(paid1), 0);
    check({tag, " dut1 done"}, int'(done1), 0);
    check({tag, " dut1 timeout"}, int'(tmo1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    ev_t e;
    rst_n = 1'b0;
    buy0 = 1'b0; cola0 = 1'b0; buy1 = 1'b0; cola1 = 1'b0;
    bz_from[0] = 1; bz_to[0] = 0;
    bz_from[1] = 1; bz_to[1] = 0;
    repeat (3) @(negedge clk);
    expect_quiet("in reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    expect_quiet("idle after reset");

    fork
      drive(0, 40, 1'b0);
      begin
        drive(1, 25, 1'b0);
        drive(1, 6, 1'b1);
      end
    join

    // Reset asserted while dut0 sits in the gap after its first coin
    @(negedge clk);
    c = cyc;
    buy0 = 1'b1;
    e.cyc = c + 1; e.kind = 0; e.paid = 1;
    q0.push_back(e);
    bz_from[0] = c + 1;
    bz_to[0]   = c + 2;
    @(negedge clk);
    buy0 = 1'b0;
    @(negedge clk);
    check("mid-gap busy before reset", int'(busy0), 1);
    check("mid-gap money before reset", int'(money0), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset money", int'(money0), 0);
    check("async reset busy", int'(busy0), 0);
    check("async reset paid", int'(paid0), 0);
    check("async reset done", int'(done0), 0);
    check("async reset timeout", int'(tmo0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    expect_quiet("after mid-gap reset");

    check("dut0 scoreboard drained", q0.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
